// File: rtl/conv_pkg.sv
// Shared definitions for the convolution-layer schedulers.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_WAIT_W,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int IMG_W   = 28;
    localparam int IMG_H   = 28;
    localparam int FILT_K  = 5;
    localparam int NUM_WTS = 75;

    // Number of positions holding a complete KxK window.
    function automatic int out_cnt(input int w, input int h, input int k);
        return (w - k + 1) * (h - k + 1);
    endfunction

endpackage

// File: rtl/conv1_raster_cnt.sv
// Raster position tracker for an incoming pixel stream.
// win_ok qualifies the pixel about to be accepted: it closes a full KxK window.
module conv1_raster_cnt
    import conv_pkg::*;
#(
    parameter int WIDTH  = IMG_W,
    parameter int HEIGHT = IMG_H,
    parameter int K      = FILT_K
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              clr,
    input  logic                              adv,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] pcnt,
    output logic                              win_ok
);

    localparam int CW = $clog2(WIDTH);
    // Row runs one past the last line after the final pixel, so size for HEIGHT.
    localparam int RW = $clog2(HEIGHT + 1);

    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_K   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_K   = RW'(K - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Advance col/row/pcnt in raster order on every accepted pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst || clr) begin
            col  <= '0;
            row  <= '0;
            pcnt <= '0;
        end else if (adv) begin
            pcnt <= pcnt + 1'b1;
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign win_ok = (col >= COL_K) && (row >= ROW_K);

endmodule

// File: rtl/conv1_sched.sv
// First conv layer scheduler: weight load, pixel streaming into the line
// buffer, window-valid generation and result counting.
module conv1_sched
    import conv_pkg::*;
#(
    parameter int WIDTH  = IMG_W,
    parameter int HEIGHT = IMG_H,
    parameter int K      = FILT_K,
    parameter int NUM_W  = NUM_WTS
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       start,
    input  logic [7:0] w_data,
    input  logic       w_valid,
    output logic       w_ready,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       weight_valid,
    output logic [7:0] filter,
    input  logic       weight_done,
    output logic       pix_we,
    output logic [7:0] pix_data,
    output logic       win_valid,
    input  logic       conv_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam int NPIX    = WIDTH * HEIGHT;
    localparam int OUT_CNT = out_cnt(WIDTH, HEIGHT, K);
    localparam int PW      = $clog2(NPIX + 1);
    localparam int OW      = $clog2(OUT_CNT + 1);
    localparam int WW      = $clog2(NUM_W + 1);
    // Accept -> pix_we -> win_valid
    localparam int STAGES  = 2;

    localparam logic [PW-1:0] NPIX_C    = PW'(NPIX);
    localparam logic [PW-1:0] PLAST_C   = PW'(NPIX - 1);
    localparam logic [OW-1:0] OUT_CNT_C = OW'(OUT_CNT);
    localparam logic [OW-1:0] OLAST_C   = OW'(OUT_CNT - 1);
    localparam logic [WW-1:0] NUM_W_C   = WW'(NUM_W);
    localparam logic [WW-1:0] WLAST_C   = WW'(NUM_W - 1);

    state_t            state, state_nxt;
    logic [WW-1:0]     wcnt;
    logic [OW-1:0]     ocnt;
    logic [PW-1:0]     pcnt;
    logic              win_ok;
    logic              w_acc, s_acc, win_acc;
    logic              counting, oc_hit, pre_weights;
    logic [STAGES:1]   vld_pipe;

    assign w_ready     = (state == S_LOAD_W) && (wcnt < NUM_W_C);
    assign s_ready     = (state == S_RUN) && (pcnt < NPIX_C);
    assign w_acc       = w_valid && w_ready;
    assign s_acc       = s_valid && s_ready;
    assign win_acc     = s_acc && win_ok;
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_DONE);
    assign counting    = (state == S_RUN) || (state == S_DRAIN);
    assign pre_weights = (state == S_IDLE) || (state == S_LOAD_W) || (state == S_WAIT_W);
    // Final result arrives this cycle, or the count is already complete.
    assign oc_hit      = (ocnt >= OUT_CNT_C) || (conv_valid && (ocnt == OLAST_C));
    assign win_valid   = vld_pipe[STAGES];

    conv1_raster_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .K      (K)
    ) u_raster (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clr    (state == S_DONE),
        .adv    (s_acc),
        .pcnt   (pcnt),
        .win_ok (win_ok)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = weight_done ? S_RUN : S_LOAD_W;
            S_LOAD_W: if ((wcnt >= NUM_W_C) || (w_acc && (wcnt == WLAST_C)))
                          state_nxt = S_WAIT_W;
            S_WAIT_W: if (weight_done) state_nxt = S_RUN;
            S_RUN: begin
                if (oc_hit)                            state_nxt = S_DONE;
                else if (s_acc && (pcnt == PLAST_C))   state_nxt = S_DRAIN;
            end
            S_DRAIN:  if (oc_hit) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Weight path: register accepted bytes; wcnt survives frames so weights can be reused.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            weight_valid <= 1'b0;
            filter       <= '0;
            wcnt         <= '0;
        end else begin
            weight_valid <= w_acc;
            if (w_acc) begin
                filter <= w_data;
                wcnt   <= wcnt + 1'b1;
            end
        end
    end

    // Pixel path: register accepted bytes toward the line buffer, unmodified.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pix_we   <= 1'b0;
            pix_data <= '0;
        end else begin
            pix_we <= s_acc;
            if (s_acc) pix_data <= s_data;
        end
    end

    // Window-valid delay line, aligned one cycle behind the line-buffer write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[STAGES-1:1], win_acc};
    end

    // Result counter; cleared on the way back to IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rst)                                             ocnt <= '0;
        else if (state == S_DONE)                               ocnt <= '0;
        else if (counting && conv_valid && (ocnt < OUT_CNT_C))  ocnt <= ocnt + 1'b1;
    end

    // Sticky error: results before weights are ready, or more results than windows.
    always_ff @(posedge i_clk) begin
        if (!i_rst)                                                err <= 1'b0;
        else if (conv_valid && (pre_weights || (ocnt >= OUT_CNT_C))) err <= 1'b1;
    end

endmodule

// File: tb/tb_conv1_sched.sv
// Self-checking bench for conv1_sched: random pixel data and backpressure,
// datapath model returning one result 3 cycles after each window strobe.
module tb_conv1_sched;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int K    = 5;
    localparam int NW   = 75;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - K + 1) * (H - K + 1);

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] w_data = '0;
    logic       w_valid = 1'b0;
    logic       w_ready;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       weight_valid;
    logic [7:0] filter;
    logic       weight_done = 1'b0;
    logic       pix_we;
    logic [7:0] pix_data;
    logic       win_valid;
    logic       conv_valid = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       err;

    always #5 i_clk = ~i_clk;

    conv1_sched dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .start        (start),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .weight_valid (weight_valid),
        .filter       (filter),
        .weight_done  (weight_done),
        .pix_we       (pix_we),
        .pix_data     (pix_data),
        .win_valid    (win_valid),
        .conv_valid   (conv_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .err          (err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] wt  [NW];
    logic [7:0] pix [NPIX];

    // Model state: pixel/weight index accepted in the previous cycles (-1 = none).
    int  prev_acc = -1, prev2_acc = -1, prev_wacc = -1;
    int  pix_idx = 0, w_idx = 0, n_pixwe = 0, n_win = 0, n_wv = 0, cv_sent = 0;
    int  s_prob = 100, acc116_cyc = -1, first_win_cyc = -1;
    bit  fd_exp = 0, fd_seen = 0, any_wready = 0;
    bit  p_mode = 0, w_mode = 0, start_req = 0, cv_force = 0, rst_req = 0;
    logic [2:0] wv_hist = '0;
    int  win_q[$];
    int  ref_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs of the new cycle against the model, then drive inputs.
    task automatic tick();
        bit exp_win;
        int p;
        @(posedge i_clk);
        #1;
        cyc++;
        p       = prev2_acc;
        exp_win = (p >= 0) && ((p / W) >= K - 1) && ((p % W) >= K - 1);
        chk("pix_we", pix_we, prev_acc >= 0);
        if (prev_acc >= 0) chk("pix_data", pix_data, pix[prev_acc]);
        chk("win_valid", win_valid, exp_win);
        chk("weight_valid", weight_valid, prev_wacc >= 0);
        if (prev_wacc >= 0) chk("filter", filter, wt[prev_wacc]);
        chk("frame_done", frame_done, fd_exp);
        if (pix_we === 1'b1)       n_pixwe++;
        if (weight_valid === 1'b1) n_wv++;
        if (frame_done === 1'b1)   fd_seen = 1;
        if (w_ready === 1'b1)      any_wready = 1;
        if (win_valid === 1'b1) begin
            n_win++;
            win_q.push_back(p);
            if (first_win_cyc < 0) first_win_cyc = cyc;
        end

        i_rst     = rst_req;
        prev2_acc = i_rst ? prev_acc : -1;
        prev_acc  = -1;
        prev_wacc = -1;
        fd_exp    = 0;

        // Datapath model: result 3 cycles after each window strobe.
        conv_valid = cv_force | (wv_hist[2] & i_rst);
        if (wv_hist[2] && i_rst) begin
            cv_sent++;
            if (cv_sent == NOUT) fd_exp = 1;
        end
        wv_hist  = i_rst ? {wv_hist[1:0], win_valid === 1'b1} : 3'b000;
        cv_force = 0;
        if (!i_rst)          weight_done = 1'b0;
        else if (n_wv == NW) weight_done = 1'b1;

        start     = start_req;
        start_req = 0;

        w_valid = 1'b0;
        if (w_mode && w_idx < NW) begin
            w_valid = 1'b1;
            w_data  = wt[w_idx];
            if (w_ready === 1'b1 && i_rst) begin
                prev_wacc = w_idx;
                w_idx++;
            end
        end

        s_valid = 1'b0;
        if (p_mode && pix_idx < NPIX && $urandom_range(99) < s_prob) begin
            s_valid = 1'b1;
            s_data  = pix[pix_idx];
            if (s_ready === 1'b1 && i_rst) begin
                prev_acc = pix_idx;
                if (pix_idx == 116) acc116_cyc = cyc;
                pix_idx++;
            end
        end
    endtask

    task automatic new_frame(input int prob);
        pix_idx = 0; w_idx = 0; n_pixwe = 0; n_win = 0; n_wv = 0; cv_sent = 0;
        fd_seen = 0; any_wready = 0; acc116_cyc = -1; first_win_cyc = -1;
        win_q.delete();
        s_prob = prob;
        foreach (pix[i]) pix[i] = 8'($urandom);
        p_mode = 1; w_mode = 1; start_req = 1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!fd_seen && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_in_time"}, fd_seen, 1);
        tick();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_s_ready_after"}, s_ready, 0);
        chk({tag, "_pix_count"}, n_pixwe, NPIX);
        chk({tag, "_win_count"}, n_win, NOUT);
        chk({tag, "_result_count"}, cv_sent, NOUT);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst_w_ready", w_ready, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_weight_valid", weight_valid, 0);
        chk("rst_pix_we", pix_we, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_filter", filter, 0);
        chk("rst_pix_data", pix_data, 0);
        rst_req = 1;
        tick();

        // Fresh weight load followed by a full unstalled frame
        foreach (wt[i]) wt[i] = 8'(i);
        new_frame(100);
        tick();
        tick();
        chk("s1_w_ready", w_ready, 1);
        chk("s1_busy", busy, 1);
        n = 0;
        while (n_wv < NW && n < 300) begin
            tick();
            n++;
        end
        chk("s1_weight_count", n_wv, NW);
        wait_done("s2", 4000);
        chk("s2_first_win_latency", first_win_cyc - acc116_cyc, 2);
        ref_q = win_q;

        // Backpressured frame, weights reused
        new_frame(50);
        wait_done("s3", 8000);
        chk("s3_no_w_ready", any_wready, 0);
        chk("s3_no_weights", n_wv, 0);
        chk("s3_win_positions_len", win_q.size(), ref_q.size());
        for (int i = 0; i < win_q.size() && i < ref_q.size(); i++)
            chk("s3_win_position", win_q[i], ref_q[i]);

        // Weights held: IDLE->RUN directly; stray start mid-RUN is ignored
        new_frame(80);
        tick();
        tick();
        chk("s4_s_ready", s_ready, 1);
        chk("s4_w_ready", w_ready, 0);
        n = 0;
        while (pix_idx < 400 && n < 2000) begin
            tick();
            n++;
        end
        start_req = 1;
        tick();
        wait_done("s4", 6000);
        chk("s4_no_w_ready", any_wready, 0);

        // Reset in the middle of RUN
        new_frame(100);
        n = 0;
        while (pix_idx < 300 && n < 2000) begin
            tick();
            n++;
        end
        rst_req = 0;
        tick();
        rst_req = 1;
        tick();
        chk("s5_busy", busy, 0);
        chk("s5_w_ready", w_ready, 0);
        chk("s5_s_ready", s_ready, 0);
        chk("s5_weight_valid", weight_valid, 0);
        chk("s5_pix_we", pix_we, 0);
        chk("s5_win_valid", win_valid, 0);
        chk("s5_frame_done", frame_done, 0);
        chk("s5_err", err, 0);
        chk("s5_filter", filter, 0);
        chk("s5_pix_data", pix_data, 0);

        // Reload after reset (weight_done was dropped)
        foreach (wt[i]) wt[i] = 8'($urandom);
        new_frame(100);
        tick();
        tick();
        chk("s5_reload_w_ready", w_ready, 1);
        wait_done("s5", 5000);
        chk("s5_reload_weights", n_wv, NW);

        // Stray result in IDLE sets a sticky error
        p_mode = 0; w_mode = 0;
        cv_force = 1;
        tick();
        tick();
        chk("s6_err_set", err, 1);
        chk("s6_idle", busy, 0);
        repeat (5) tick();
        chk("s6_err_sticky", err, 1);
        rst_req = 0;
        tick();
        rst_req = 1;
        tick();
        chk("s6_err_cleared", err, 0);

        // Start and stray result together: start taken, err set
        weight_done = 1'b1;
        cv_force  = 1;
        start_req = 1;
        tick();
        tick();
        chk("s6_start_taken", busy, 1);
        chk("s6_err_with_start", err, 1);
        rst_req = 0;
        tick();
        rst_req = 1;
        tick();
        chk("s6_final_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
